// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator toward a byte-lane data memory.
// Word-crossing accesses are split into two aligned beats; load data is merged and extended.
module load_store_unit #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_re,
  output logic [3:0]            mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int unsigned WordW = DM_ADDRESS - 2;

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StWait} state_e;
  state_e state_q, state_d;

  logic                  load_q, load_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     data0_q, data0_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;

  logic                  accept;
  logic                  illegal;
  logic [1:0]            offset;
  logic [WordW-1:0]      word0;
  logic [WordW-1:0]      word1;
  logic [3:0]            size_mask;
  logic [7:0]            lane_mask;
  logic                  split;
  logic [2*DATA_W-1:0]   store_win;
  logic [2*DATA_W-1:0]   load_win;
  logic [DATA_W-1:0]     load_raw;
  logic [DATA_W-1:0]     load_ext;
  logic                  unused_addr;

  // Address bits beyond the memory size are intentionally ignored.
  assign unused_addr = ^req_addr[31:DM_ADDRESS];

  assign accept  = req_valid & req_ready;
  assign illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11) |
                   (req_funct3[2] & req_write) | (req_read == req_write);

  assign offset = addr_q[1:0];
  assign word0  = addr_q[DM_ADDRESS-1:2];
  assign word1  = word0 + WordW'(1);

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign lane_mask = {4'b0000, size_mask} << offset;
  assign split     = |lane_mask[7:4];
  assign store_win = {{DATA_W{1'b0}}, wdata_q} << {offset, 3'b000};

  // In WAIT, mem_rdata holds the last beat; beat0 data was captured in BEAT1 for splits.
  assign load_win = split ? {mem_rdata, data0_q} : {{DATA_W{1'b0}}, mem_rdata};
  assign load_raw = DATA_W'(load_win >> {offset, 3'b000});

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   load_ext = funct3_q[2] ? {24'b0, load_raw[7:0]} :
                                        {{24{load_raw[7]}}, load_raw[7:0]};
      2'b01:   load_ext = funct3_q[2] ? {16'b0, load_raw[15:0]} :
                                        {{16{load_raw[15]}}, load_raw[15:0]};
      default: load_ext = load_raw;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && !illegal) state_d = StBeat0;
      StBeat0: state_d = split ? StBeat1 : (load_q ? StWait : StIdle);
      StBeat1: state_d = load_q ? StWait : StIdle;
      StWait:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs; memory is only driven during the two beat states
  always_comb begin
    req_ready = (state_q == StIdle) & ~reset;
    mem_re    = 1'b0;
    mem_wr    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StBeat0: begin
        mem_addr  = {word0, 2'b00};
        mem_re    = load_q;
        mem_wr    = load_q ? 4'b0000 : lane_mask[3:0];
        mem_wdata = load_q ? '0 : store_win[DATA_W-1:0];
      end
      StBeat1: begin
        mem_addr  = {word1, 2'b00};
        mem_re    = load_q;
        mem_wr    = load_q ? 4'b0000 : lane_mask[7:4];
        mem_wdata = load_q ? '0 : store_win[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  always_comb begin
    load_d      = load_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data0_d     = data0_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    if (accept) begin
      load_d   = req_read;
      funct3_d = req_funct3;
      addr_d   = req_addr[DM_ADDRESS-1:0];
      wdata_d  = req_wdata;
      if (illegal) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
    end
    unique case (state_q)
      StBeat0: if (!split && !load_q) rsp_valid_d = 1'b1;
      StBeat1: begin
        if (load_q) data0_d = mem_rdata;
        else        rsp_valid_d = 1'b1;
      end
      StWait: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_ext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_q      <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      data0_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      load_q      <= load_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data0_q     <= data0_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-addressed reference model plus
// a 1-cycle-latency lane memory, directed vectors and randomized traffic.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_re;
  logic [3:0]  mem_wr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic        mem_load = 1'b0;
  logic [31:0] init_words [128];
  logic [31:0] env_mem [128];
  logic [7:0]  ref_mem [512];

  logic [8:0]  obs_addr [$];
  logic [3:0]  obs_wr [$];
  logic [31:0] obs_wd [$];
  logic        obs_re [$];
  logic        obs_both, obs_ready_acc, obs_ready_rsp, obs_err, obs_timeout;
  logic [31:0] obs_rdata;
  int          obs_lat;

  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_re(mem_re), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory: byte-lane writes, registered reads.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int w = 0; w < 128; w++) env_mem[w] <= init_words[w];
    end else begin
      if (mem_re) mem_rdata <= env_mem[mem_addr[8:2]];
      for (int i = 0; i < 4; i++)
        if (mem_wr[i]) env_mem[mem_addr[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_illegal(input logic rd, input logic wr, input logic [2:0] f3);
    return (rd == wr) || (f3 == 3'd3) || (f3 >= 3'd6) || (f3 >= 3'd4 && wr);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int          size = size_of(f3);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[a[8:0] + 9'(i)];
    if (!f3[2] && size < 4 && v[8*size-1])
      for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < size_of(f3); i++) ref_mem[a[8:0] + 9'(i)] = wd[8*i +: 8];
  endtask

  // Presents one request and records everything seen on the memory side until rsp_valid.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic noise);
    obs_addr.delete(); obs_wr.delete(); obs_wd.delete(); obs_re.delete();
    obs_both = 1'b0; obs_timeout = 1'b1; obs_lat = 0;
    obs_err = 1'b0; obs_rdata = 32'h0; obs_ready_rsp = 1'b0;
    req_valid = 1'b1; req_read = rd; req_write = wr; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    obs_ready_acc = req_ready;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (mem_re || mem_wr != 4'b0000) begin
        obs_addr.push_back(mem_addr); obs_wr.push_back(mem_wr);
        obs_wd.push_back(mem_wdata); obs_re.push_back(mem_re);
      end
      if (mem_re && mem_wr != 4'b0000) obs_both = 1'b1;
      if (rsp_valid) begin
        obs_lat = cyc; obs_err = rsp_err; obs_rdata = rsp_rdata;
        obs_ready_rsp = req_ready; obs_timeout = 1'b0;
        break;
      end
      if (noise) begin
        req_valid = 1'b1; req_read = 1'($urandom); req_write = 1'($urandom);
        req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_load = 1'b1;
    @(posedge clk);
    #1 mem_load = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++;
      $display("FAIL rst_ready_in_reset: got %b want 0", req_ready); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++;
      $display("FAIL rst_ready: got %b want 1", req_ready); end
    n_cmp++; if ({rsp_valid, rsp_err, mem_re, mem_wr} !== 7'b0) begin n_bad++;
      $display("FAIL rst_ctrl: got %b want 0", {rsp_valid, rsp_err, mem_re, mem_wr}); end
    n_cmp++; if ({rsp_rdata, mem_addr, mem_wdata} !== 73'b0) begin n_bad++;
      $display("FAIL rst_data: got %h want 0", {rsp_rdata, mem_addr, mem_wdata}); end
  endtask

  task automatic test_directed;
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    n_cmp++; if (obs_ready_acc !== 1'b1) begin n_bad++;
      $display("FAIL lw_ready: got %b want 1", obs_ready_acc); end
    n_cmp++; if (obs_lat !== 3) begin n_bad++;
      $display("FAIL lw_lat: got %0d want 3", obs_lat); end
    n_cmp++; if ({obs_err, obs_rdata} !== {1'b0, 32'h8899AABB}) begin n_bad++;
      $display("FAIL lw_data: got %b/%h want 0/8899aabb", obs_err, obs_rdata); end
    n_cmp++; if (obs_addr.size() !== 1) begin n_bad++;
      $display("FAIL lw_beats: got %0d want 1", obs_addr.size()); end
    n_cmp++; if ({obs_addr[0], obs_re[0], obs_wr[0]} !== {9'h010, 1'b1, 4'b0000}) begin n_bad++;
      $display("FAIL lw_beat0: got %h/%b/%b want 010/1/0000", obs_addr[0], obs_re[0], obs_wr[0]);
    end
    issue(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
    n_cmp++; if (obs_rdata !== 32'hFFFFFF88) begin n_bad++;
      $display("FAIL lb_data: got %h want ffffff88", obs_rdata); end
    issue(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
    n_cmp++; if (obs_rdata !== 32'h00000088) begin n_bad++;
      $display("FAIL lbu_data: got %h want 00000088", obs_rdata); end
    issue(1'b1, 1'b0, 3'b101, 32'h11, 32'h0, 1'b0);
    n_cmp++; if ({obs_rdata, obs_addr.size()} !== {32'h000099AA, 32'd1}) begin n_bad++;
      $display("FAIL lhu_data: got %h/%0d want 000099aa/1", obs_rdata, obs_addr.size()); end
    issue(1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 1'b0);
    n_cmp++; if ({obs_lat, obs_rdata} !== {32'd4, 32'h33448899}) begin n_bad++;
      $display("FAIL lw_split: got %0d/%h want 4/33448899", obs_lat, obs_rdata); end
    n_cmp++; if ({obs_addr.size(), obs_addr[0], obs_addr[1]} !== {32'd2, 9'h010, 9'h014}) begin
      n_bad++; $display("FAIL lw_split_beats: got %0d %h %h want 2 010 014",
                        obs_addr.size(), obs_addr[0], obs_addr[1]); end
    issue(1'b0, 1'b1, 3'b001, 32'h13, 32'h0000BEEF, 1'b0);
    model_store(3'b001, 32'h13, 32'h0000BEEF);
    n_cmp++; if ({obs_lat, obs_err, obs_rdata} !== {32'd3, 1'b0, 32'h0}) begin n_bad++;
      $display("FAIL sh_rsp: got %0d/%b/%h want 3/0/0", obs_lat, obs_err, obs_rdata); end
    n_cmp++; if ({obs_addr[0], obs_wr[0], obs_wd[0]} !== {9'h010, 4'b1000, 32'hEF000000}) begin
      n_bad++; $display("FAIL sh_beat0: got %h/%b/%h want 010/1000/ef000000",
                        obs_addr[0], obs_wr[0], obs_wd[0]); end
    n_cmp++; if ({obs_addr[1], obs_wr[1], obs_wd[1], obs_re[1]} !==
                 {9'h014, 4'b0001, 32'h000000BE, 1'b0}) begin
      n_bad++; $display("FAIL sh_beat1: got %h/%b/%h/%b want 014/0001/000000be/0",
                        obs_addr[1], obs_wr[1], obs_wd[1], obs_re[1]); end
  endtask

  task automatic test_illegal;
    logic [4:0] cases [5] = '{5'b10_011, 5'b01_100, 5'b11_010, 5'b00_000, 5'b10_111};
    foreach (cases[c]) begin
      issue(cases[c][4], cases[c][3], cases[c][2:0], $urandom, $urandom, 1'b0);
      n_cmp++; if ({obs_lat, obs_err, obs_rdata} !== {32'd1, 1'b1, 32'h0}) begin n_bad++;
        $display("FAIL illegal_rsp[%0d]: got %0d/%b/%h want 1/1/0", c, obs_lat, obs_err,
                 obs_rdata); end
      n_cmp++; if ({obs_addr.size(), obs_ready_rsp} !== {32'd0, 1'b1}) begin n_bad++;
        $display("FAIL illegal_mem[%0d]: got %0d beats ready %b want 0/1", c, obs_addr.size(),
                 obs_ready_rsp); end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_v, wd;
    exp_v = model_load(3'b010, 32'h1FE);
    issue(1'b1, 1'b0, 3'b010, 32'h1FE, 32'h0, 1'b0);
    n_cmp++; if ({obs_addr.size(), obs_addr[0], obs_addr[1]} !== {32'd2, 9'h1FC, 9'h000}) begin
      n_bad++; $display("FAIL wrap_lw_beats: got %0d %h %h want 2 1fc 000",
                        obs_addr.size(), obs_addr[0], obs_addr[1]); end
    n_cmp++; if ({obs_lat, obs_rdata} !== {32'd4, exp_v}) begin n_bad++;
      $display("FAIL wrap_lw_data: got %0d/%h want 4/%h", obs_lat, obs_rdata, exp_v); end
    wd = $urandom;
    issue(1'b0, 1'b1, 3'b001, 32'h1FF, wd, 1'b0);
    model_store(3'b001, 32'h1FF, wd);
    n_cmp++; if ({obs_addr[0], obs_wr[0], obs_addr[1], obs_wr[1]} !==
                 {9'h1FC, 4'b1000, 9'h000, 4'b0001}) begin
      n_bad++; $display("FAIL wrap_sh_beats: got %h/%b %h/%b want 1fc/1000 000/0001",
                        obs_addr[0], obs_wr[0], obs_addr[1], obs_wr[1]); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] wd, exp_v;
    wd = $urandom;
    issue(1'b0, 1'b1, 3'b010, 32'h40, wd, 1'b0);
    model_store(3'b010, 32'h40, wd);
    n_cmp++; if ({obs_lat, obs_ready_rsp} !== {32'd2, 1'b1}) begin n_bad++;
      $display("FAIL b2b_sw: got lat %0d ready %b want 2/1", obs_lat, obs_ready_rsp); end
    issue(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0);
    n_cmp++; if ({obs_ready_acc, obs_rdata} !== {1'b1, wd}) begin n_bad++;
      $display("FAIL b2b_lw: got %b/%h want 1/%h", obs_ready_acc, obs_rdata, wd); end
    issue(1'b0, 1'b1, 3'b000, 32'h41, 32'h123456A5, 1'b0);
    model_store(3'b000, 32'h41, 32'h123456A5);
    exp_v = model_load(3'b001, 32'h40);
    issue(1'b1, 1'b0, 3'b001, 32'h40, 32'h0, 1'b0);
    n_cmp++; if (obs_rdata !== exp_v) begin n_bad++;
      $display("FAIL b2b_lh: got %h want %h", obs_rdata, exp_v); end
  endtask

  task automatic test_random;
    logic        rd, wr, bad;
    logic [2:0]  f3;
    logic [31:0] a, wd, exp_v, mask;
    logic [3:0]  el [2];
    logic [31:0] ed [2];
    logic [8:0]  b, ea;
    int          size, nb, kind, j, elat;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      a = $urandom; wd = $urandom;
      if (kind == 0) begin
        rd = 1'($urandom); wr = 1'($urandom); f3 = 3'($urandom);
      end else if (kind <= 5) begin
        rd = 1'b1; wr = 1'b0; f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end else begin
        rd = 1'b0; wr = 1'b1; f3 = 3'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      bad   = model_illegal(rd, wr, f3);
      size  = size_of(f3);
      nb    = bad ? 0 : ((int'(a[1:0]) + size > 4) ? 2 : 1);
      exp_v = (bad || wr) ? 32'h0 : model_load(f3, a);
      elat  = bad ? 1 : (rd ? 2 + nb : 1 + nb);
      el[0] = 4'b0; el[1] = 4'b0; ed[0] = 32'h0; ed[1] = 32'h0;
      for (int i = 0; i < size; i++) begin
        b = a[8:0] + 9'(i);
        j = (b[8:2] == a[8:2]) ? 0 : 1;
        el[j][b[1:0]] = 1'b1;
        ed[j][8*b[1:0] +: 8] = wd[8*i +: 8];
      end
      issue(rd, wr, f3, a, wd, 1'($urandom));
      n_cmp++; if (obs_timeout) begin n_bad++;
        $display("FAIL rnd_timeout[%0d]: no rsp_valid within 12 cycles, want lat %0d", n, elat);
      end
      n_cmp++; if ({obs_ready_acc, obs_ready_rsp, obs_both} !== 3'b110) begin n_bad++;
        $display("FAIL rnd_handshake[%0d]: got %b want 110", n,
                 {obs_ready_acc, obs_ready_rsp, obs_both}); end
      n_cmp++; if (obs_lat !== elat) begin n_bad++;
        $display("FAIL rnd_lat[%0d]: got %0d want %0d", n, obs_lat, elat); end
      n_cmp++; if ({obs_err, obs_rdata} !== {bad, exp_v}) begin n_bad++;
        $display("FAIL rnd_rsp[%0d] f3=%0d a=%h: got %b/%h want %b/%h", n, f3, a, obs_err,
                 obs_rdata, bad, exp_v); end
      n_cmp++; if (obs_addr.size() !== nb) begin n_bad++;
        $display("FAIL rnd_beats[%0d]: got %0d want %0d", n, obs_addr.size(), nb); end
      for (int bt = 0; bt < nb && bt < obs_addr.size(); bt++) begin
        ea = {a[8:2], 2'b00} + 9'(4 * bt);
        n_cmp++; if ({obs_addr[bt], obs_re[bt], obs_wr[bt]} !== {ea, rd, rd ? 4'b0 : el[bt]})
        begin n_bad++;
          $display("FAIL rnd_beat[%0d.%0d]: got %h/%b/%b want %h/%b/%b", n, bt, obs_addr[bt],
                   obs_re[bt], obs_wr[bt], ea, rd, rd ? 4'b0 : el[bt]); end
        if (wr) begin
          for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{el[bt][k]}};
          n_cmp++; if ((obs_wd[bt] & mask) !== ed[bt]) begin n_bad++;
            $display("FAIL rnd_wdata[%0d.%0d]: got %h want %h", n, bt, obs_wd[bt] & mask,
                     ed[bt]); end
        end
      end
      if (!bad && wr) model_store(f3, a, wd);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] wd;
    int          seen;
    wd = $urandom;
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h12; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mem_addr, mem_wr} !== {9'h010, 4'b1100}) begin n_bad++;
      $display("FAIL rstmid_beat0: got %h/%b want 010/1100", mem_addr, mem_wr); end
    @(negedge clk);
    n_cmp++; if ({mem_addr, mem_wr} !== {9'h014, 4'b0011}) begin n_bad++;
      $display("FAIL rstmid_beat1: got %h/%b want 014/0011", mem_addr, mem_wr); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mem_wr, mem_re, req_ready, rsp_valid, mem_addr} !== 16'b0) begin n_bad++;
      $display("FAIL rstmid_after: got wr %b re %b ready %b rsp %b addr %h want all 0",
               mem_wr, mem_re, req_ready, rsp_valid, mem_addr); end
    reset = 1'b0;
    // Both beats were presented to the memory before reset took effect.
    model_store(3'b010, 32'h12, wd);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    n_cmp++; if ({seen, req_ready} !== {32'd0, 1'b1}) begin n_bad++;
      $display("FAIL rstmid_quiet: got %0d rsp ready %b want 0/1", seen, req_ready); end
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    n_cmp++; if (obs_rdata !== model_load(3'b010, 32'h10)) begin n_bad++;
      $display("FAIL rstmid_mem: got %h want %h", obs_rdata, model_load(3'b010, 32'h10)); end
  endtask

  initial begin
    for (int w = 0; w < 128; w++) begin
      init_words[w] = (w == 4) ? 32'h8899AABB : (w == 5) ? 32'h11223344 : $urandom;
      for (int i = 0; i < 4; i++) ref_mem[9'(4 * w + i)] = init_words[w][8*i +: 8];
    end
    test_reset;
    test_directed;
    test_illegal;
    test_wrap;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
